// File: rtl/usrt_tx_scheduler_pkg.sv
// Shared types and framing constants for the USRT transmit scheduler.
// Imported by the scheduler top and its arbiter.
package usrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } usrt_sched_state_t;

  localparam logic STOP_ONE    = 1'b0;
  localparam logic STOP_TWO    = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/usrt_tx_scheduler_if.sv
// Byte-stream handshake bundle between the requesters, the scheduler and the transmitter.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface usrt_tx_scheduler_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS*8-1:0] in_data;
  logic [CHANNELS-1:0]   in_last;
  logic [CHANNELS-1:0]   in_valid;
  logic [CHANNELS-1:0]   in_ready;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/usrt_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester found searching upward from ptr+1 with wrap.
module usrt_rr_arbiter
  import usrt_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]         i_req,
  input  logic [$clog2(CHANNELS)-1:0] i_ptr,
  output logic [$clog2(CHANNELS)-1:0] o_grant,
  output logic                        o_any_req
);
  localparam int IDW = $clog2(CHANNELS);

  logic [IDW:0] w_sum;
  logic [IDW:0] w_idx;

  // Walk from the lowest priority slot to the highest so the last hit is the winner
  always_comb begin
    o_grant   = {IDW{1'b0}};
    o_any_req = 1'b0;
    w_sum     = {(IDW+1){1'b0}};
    w_idx     = {(IDW+1){1'b0}};
    for (int i = CHANNELS; i >= 1; i--) begin
      w_sum     = {1'b0, i_ptr} + (IDW+1)'(i);
      w_idx     = (w_sum >= (IDW+1)'(CHANNELS)) ? (w_sum - (IDW+1)'(CHANNELS)) : w_sum;
      o_grant   = i_req[w_idx[IDW-1:0]] ? w_idx[IDW-1:0] : o_grant;
      o_any_req = o_any_req | i_req[w_idx[IDW-1:0]];
    end
  end
endmodule

// File: rtl/usrt_tx_scheduler.sv
// Message-granular round-robin scheduler sharing one USRT transmitter between CHANNELS requesters.
// Framing config is latched at grant; a programmable idle gap follows every message.
module usrt_tx_scheduler
  import usrt_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int GAP_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ctrl_init,
  input  logic [CHANNELS-1:0]         cfg_stop_bits,
  input  logic [CHANNELS-1:0]         cfg_parity_ena,
  input  logic [CHANNELS-1:0]         cfg_parity_type,
  input  logic [GAP_W-1:0]            cfg_gap,
  usrt_tx_scheduler_if.slave          bus,
  output logic                        out_init,
  output logic                        out_stop_bits,
  output logic                        out_parity_ena,
  output logic                        out_parity_type,
  output logic                        busy,
  output logic [$clog2(CHANNELS)-1:0] grant_id
);
  localparam int IDW = $clog2(CHANNELS);

  usrt_sched_state_t r_state;
  usrt_sched_state_t w_next_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_grant_id;
  logic [IDW-1:0]    w_arb_grant;
  logic              w_any_req;
  logic              w_handshake;
  logic              w_last;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_stop_bits;
  logic              r_parity_ena;
  logic              r_parity_type;

  usrt_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .i_req     (bus.in_valid),
    .i_ptr     (r_ptr),
    .o_grant   (w_arb_grant),
    .o_any_req (w_any_req)
  );

  // Next-state logic and the per-state data/handshake steering
  always_comb begin
    w_next_state  = r_state;
    bus.in_ready  = {CHANNELS{1'b0}};
    bus.out_data  = 8'h00;
    bus.out_valid = 1'b0;
    w_handshake   = 1'b0;
    w_last        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next_state = XFER;
        end else begin
          w_next_state = IDLE;
        end
      end
      XFER: begin
        bus.out_data           = bus.in_data[{r_grant_id, 3'b000} +: 8];
        bus.out_valid          = bus.in_valid[r_grant_id];
        bus.in_ready[r_grant_id] = bus.out_ready;
        w_handshake            = bus.in_valid[r_grant_id] & bus.out_ready;
        w_last                 = bus.in_last[r_grant_id];
        if (w_handshake && w_last) begin
          w_next_state = (cfg_gap == {GAP_W{1'b0}}) ? IDLE : GAP;
        end else begin
          w_next_state = XFER;
        end
      end
      GAP: begin
        // A zero count can only be reached by corruption; leave GAP rather than wrap
        if (r_gap_cnt <= GAP_W'(1)) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = GAP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, round-robin pointer, grant/config latch and gap counter
  always_ff @(posedge clk) begin
    if (reset || ctrl_init) begin
      r_state       <= IDLE;
      r_ptr         <= IDW'(CHANNELS - 1);
      r_gap_cnt     <= {GAP_W{1'b0}};
      r_grant_id    <= {IDW{1'b0}};
      r_stop_bits   <= STOP_ONE;
      r_parity_ena  <= 1'b0;
      r_parity_type <= PARITY_EVEN;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_id    <= w_arb_grant;
            r_ptr         <= w_arb_grant;
            r_stop_bits   <= cfg_stop_bits[w_arb_grant];
            r_parity_ena  <= cfg_parity_ena[w_arb_grant];
            r_parity_type <= cfg_parity_type[w_arb_grant];
          end
        end
        XFER: begin
          if (w_handshake && w_last) begin
            r_gap_cnt <= cfg_gap;
          end
        end
        GAP: begin
          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
        default: begin
          r_gap_cnt <= {GAP_W{1'b0}};
        end
      endcase
    end
  end

  assign out_init        = ctrl_init;
  assign out_stop_bits   = r_stop_bits;
  assign out_parity_ena  = r_parity_ena;
  assign out_parity_type = r_parity_type;
  assign busy            = (r_state != IDLE);
  assign grant_id        = r_grant_id;
endmodule
